// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the data memory: load/store size codes,
// controller state constants and the registered response record.
package riscv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } rsp_t;

   function automatic logic f3_illegal(input logic [2:0] f3);
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-addressed storage split into four byte lanes, each with its own write
// enable. Reads are combinational so the controller can register the result.
module dmem_bank #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane [DEPTH];

         always_ff @(posedge clk) begin
            if (we[gi]) begin
               lane[addr] <= wdata[8*gi +: 8];
            end
         end

         assign rdata[8*gi +: 8] = lane[addr];
      end
   endgenerate

endmodule

// File: rtl/data_mem_sized.sv
// RV32I data memory controller: sized/aligned loads and stores with a
// configurable number of wait cycles and a valid/ready response handshake.
module data_mem_sized
   import riscv_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int WAIT  = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [2:0] CNT_INIT = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

   logic [1:0]  state_reg;
   logic [2:0]  cnt_reg;
   logic        req_ready_reg;
   logic        rsp_valid_reg;
   rsp_t        rsp_reg;
   rsp_t        rsp_next;

   logic        accept;
   logic        err;
   logic [1:0]  size;
   logic [3:0]  byte_en;
   logic [3:0]  bank_we;
   logic [31:0] wdata_rep;
   logic [31:0] word;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [31:0] load_val;

   assign accept = req_valid && req_ready_reg;
   assign size   = req_funct3[1:0];
   assign err    = f3_illegal(req_funct3)
                || (|req_addr[31:AW+2])
                || ((size == 2'b01) && req_addr[0])
                || ((size == 2'b10) && (|req_addr[1:0]));

   always_comb begin
      byte_en   = 4'b1111;
      wdata_rep = req_wdata;
      case (size)
         2'b00: begin
            byte_en   = 4'b0001 << req_addr[1:0];
            wdata_rep = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            byte_en   = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // The write lands on the accept edge; rst blocks it so a request seen
   // during reset cannot touch memory.
   assign bank_we = (accept && req_we && !err && !rst) ? byte_en : 4'b0000;

   dmem_bank #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_bank (
      .clk   (clk),
      .we    (bank_we),
      .addr  (req_addr[AW+1:2]),
      .wdata (wdata_rep),
      .rdata (word)
   );

   always_comb begin
      case (req_addr[1:0])
         2'd0:    lane_byte = word[7:0];
         2'd1:    lane_byte = word[15:8];
         2'd2:    lane_byte = word[23:16];
         default: lane_byte = word[31:24];
      endcase
      lane_half = req_addr[1] ? word[31:16] : word[15:0];
      case (req_funct3)
         F3_B:    load_val = {{24{lane_byte[7]}}, lane_byte};
         F3_H:    load_val = {{16{lane_half[15]}}, lane_half};
         F3_W:    load_val = word;
         F3_BU:   load_val = {24'd0, lane_byte};
         F3_HU:   load_val = {16'd0, lane_half};
         default: load_val = 32'd0;
      endcase
      rsp_next.err   = err;
      rsp_next.rdata = (err || req_we) ? 32'd0 : load_val;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= 3'd0;
         req_ready_reg <= 1'b1;
         rsp_valid_reg <= 1'b0;
         rsp_reg       <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (accept) begin
                  rsp_reg       <= rsp_next;
                  req_ready_reg <= 1'b0;
                  if (WAIT == 0) begin
                     state_reg     <= ST_RESP;
                     rsp_valid_reg <= 1'b1;
                  end else begin
                     state_reg <= ST_WAIT;
                     cnt_reg   <= CNT_INIT;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt_reg == 3'd0) begin
                  state_reg     <= ST_RESP;
                  rsp_valid_reg <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg - 3'd1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state_reg     <= ST_IDLE;
                  rsp_valid_reg <= 1'b0;
                  req_ready_reg <= 1'b1;
                  rsp_reg       <= '0;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign req_ready = req_ready_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_rdata = rsp_reg.rdata;
   assign rsp_err   = rsp_reg.err;

endmodule

// File: doc/data_mem_sized.md
DATA_MEM_SIZED -- requirements
Module: data_mem_sized

Interface
- REQ-001: Parameter DEPTH, default 256, SHALL set the number of 32-bit words; power of two, 4..4096.
- REQ-002: Parameter WAIT, default 0, SHALL set the extra wait cycles per access, 0..7.
- REQ-003: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
- REQ-004: rst  input  1  SHALL be a synchronous, active-high reset.
- REQ-005: req_valid  input  1  request present.
- REQ-006: req_ready  output  1  block can accept a request.
- REQ-007: req_we  input  1  1 = store, 0 = load.
- REQ-008: req_funct3  input  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- REQ-009: req_addr  input  32  byte address.
- REQ-010: req_wdata  input  32  store data, right-aligned (byte/half in low bits).
- REQ-011: rsp_valid  output  1  response present.
- REQ-012: rsp_ready  input  1  consumer accepts the response.
- REQ-013: rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
- REQ-014: rsp_err  output  1  request was misaligned, out of range or had an illegal size.

Function
- REQ-015: The FSM SHALL have three states, IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
- REQ-016: A request SHALL be accepted on the edge where req_valid and req_ready are both 1; the FSM goes to WAIT if WAIT>0, otherwise to RESP.
- REQ-017: In WAIT, a counter loaded with WAIT-1 at accept SHALL decrement each cycle; the FSM goes to RESP when the counter reaches 0.
- REQ-018: In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_err SHALL hold stable until the rsp_ready edge; the FSM then returns to IDLE.
- REQ-019: First response latency SHALL be WAIT+1 cycles after accept; the next accept is possible one cycle after the response handshake.
- REQ-020: Word index SHALL be req_addr[AW+1:2], where AW = clog2(DEPTH).
- REQ-021: An error SHALL be raised when any of these holds: size H/HU with addr[0]=1; size W with addr[1:0]!=0; addr[31:AW+2]!=0; funct3 in {011, 110, 111}.
- REQ-022: An erroring request SHALL NOT modify memory and SHALL respond with rsp_err=1 and rsp_rdata=0.
- REQ-023: A legal store SHALL write memory on the accept edge, using byte enables:
  - B: one lane selected by addr[1:0];
  - H: lanes {1,0} or {3,2} selected by addr[1];
  - W: all four lanes.
  - Data SHALL be replicated to the selected lanes; non-enabled bytes SHALL be unchanged.
- REQ-024: A legal store SHALL respond with rsp_err=0 and rsp_rdata=0.
- REQ-025: A legal load SHALL capture the word at accept, select the addressed byte/half, then sign-extend for B/H or zero-extend for BU/HU; W passes through.
- REQ-026: A load following a store to the same word SHALL return the stored data; there is no stale read.
- REQ-027: req_wdata bits above the access size SHALL be ignored.
- REQ-028: rsp_ready held high with rsp_valid low SHALL have no effect; req_valid outside IDLE SHALL be ignored and not queued.

Reset
- REQ-029: On rst the block SHALL force state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0; req_ready is 1 on the first cycle after reset.
- REQ-030: Memory contents SHALL NOT be reset; a store accepted before reset remains written.
- REQ-031: A request in flight when rst asserts SHALL be dropped with no response.

Structure
- REQ-032: The funct3 size encodings and the state enumeration SHALL live in the shared riscv package.
- REQ-033: Storage SHALL be one sub-module, dmem_bank, with four byte-lane arrays, per-lane write enables and a synchronous write port; the controller instantiates it once.
- REQ-034: All outputs SHALL be registered.

Verification
- REQ-035: WAIT=0: SW 0xDEADBEEF to 0x10, then LW from 0x10 -> rsp_rdata=0xDEADBEEF with rsp_valid one cycle after accept.
- REQ-036: SB 0x80 to 0x11, then LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0xDEAD80EF.
- REQ-037: LH from 0x13 -> rsp_err=1 and rsp_rdata=0; SW 0x12345678 to 0x402 (DEPTH=256) -> rsp_err=1, and a later LW 0x400 still returns rsp_err=1 with memory unchanged.
- REQ-038: WAIT=3 with rsp_ready held low 5 cycles: rsp_valid rises 4 cycles after accept, holds stable, and req_ready=0 throughout.
- REQ-039: Assert rst during WAIT -> no response follows; next cycle req_ready=1 and rsp_valid=0.
- REQ-040: funct3=011 load -> rsp_err=1.
